// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ engines.
// Read ownership is tracked in an in-order FIFO so returning beats reach their issuer.
module mem_port_arbiter #(
    parameter int N_REQ  = 2,
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32,
    parameter int OUTST  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*MEM_AW-1:0]   req_addr,
    input  logic [N_REQ*MEM_DW-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_vld,
    output logic [MEM_DW-1:0]         rsp_rdata,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [MEM_DW-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rdata_vld,
    input  logic [MEM_DW-1:0]         mem_rdata,
    output logic [$clog2(OUTST):0]    outst_cnt,
    output logic                      err_orphan
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(OUTST);
    localparam int CW = PW + 1;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [N_REQ-1:0] elig;
    logic             slot_free;
    logic             pop;
    logic             push;
    logic             read_room;
    logic [IW-1:0]    owner_fifo [OUTST];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign slot_free = ~mem_req | mem_ready;
    assign pop       = mem_rdata_vld & (outst_cnt != '0);
    // A beat retiring this cycle frees its FIFO entry, so a full FIFO may still take a read.
    assign read_room = (outst_cnt < CW'(OUTST)) | pop;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = rst_n & req[i] & slot_free & (req_write[i] | read_room);
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign push = gnt_any & ~req_write[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            outst_cnt  <= '0;
            rsp_vld    <= '0;
            rsp_rdata  <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (slot_free) begin
                if (gnt_any) begin
                    mem_req   <= 1'b1;
                    mem_write <= req_write[gnt_idx];
                    mem_addr  <= req_addr[gnt_idx*MEM_AW +: MEM_AW];
                    mem_wdata <= req_wdata[gnt_idx*MEM_DW +: MEM_DW];
                    rr_ptr    <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                end else begin
                    mem_req <= 1'b0;
                end
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase

            rsp_vld <= '0;
            if (pop) begin
                rsp_vld[owner_fifo[rd_ptr]] <= 1'b1;
                rsp_rdata                   <= mem_rdata;
            end

            if (mem_rdata_vld && outst_cnt == '0) err_orphan <= 1'b1;
        end
    end

    // Owner storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) owner_fifo[wr_ptr] <= gnt_idx;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with N_REQ=2, OUTST=4.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  rsp_vld;
    logic [31:0] rsp_rdata;
    logic        mem_req;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rdata_vld;
    logic [31:0] mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_orphan;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_REQ(2), .MEM_AW(16), .MEM_DW(32), .OUTST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .mem_req(mem_req),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata_vld(mem_rdata_vld),
        .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .err_orphan(err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req           = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_ready     = 1'b0;
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_outst", outst_cnt, 3'd0);
        chk("rst_orphan", err_orphan, 1'b0);
        chk("rst_rsp_vld", rsp_vld, 2'b00);
        rst_n = 1'b1;

        // single requester read
        req = 2'b01; req_addr[15:0] = 16'h0010; mem_ready = 1'b1;
        #1 chk("s1_gnt", gnt, 2'b01);
        tick();
        chk("s1_mem_req", mem_req, 1'b1);
        chk("s1_mem_addr", mem_addr, 16'h0010);
        chk("s1_mem_write", mem_write, 1'b0);
        chk("s1_outst", outst_cnt, 3'd1);
        req = 2'b00;
        #1 chk("s1_gnt_idle", gnt, 2'b00);
        tick();
        chk("s1_mem_req_drop", mem_req, 1'b0);
        mem_rdata_vld = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("s1_rsp_vld", rsp_vld, 2'b01);
        chk("s1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("s1_outst_done", outst_cnt, 3'd0);
        mem_rdata_vld = 1'b0; mem_rdata = 32'h0;
        tick();
        chk("s1_rsp_idle", rsp_vld, 2'b00);
        chk("s1_rdata_hold", rsp_rdata, 32'hDEADBEEF);

        // full contention, outstanding limit, write bypass, grant with pop
        do_reset();
        req = 2'b11; req_write = 2'b00; mem_ready = 1'b1;
        req_addr = {16'h0B00, 16'h0A00};
        for (int k = 0; k < 4; k++) begin
            #1 chk("s2_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("s2_mem_addr", mem_addr, (k % 2 == 0) ? 16'h0A00 : 16'h0B00);
        end
        chk("s2_outst_full", outst_cnt, 3'd4);
        #1 chk("s2_read_blocked", gnt, 2'b00);
        req_write = 2'b10; req_wdata[63:32] = 32'h0000CAFE;
        #1 chk("s2_write_gnt", gnt, 2'b10);
        tick();
        chk("s2_write_issue", mem_write, 1'b1);
        chk("s2_write_data", mem_wdata, 32'h0000CAFE);
        chk("s2_outst_write", outst_cnt, 3'd4);
        req = 2'b01; req_write = 2'b00; req_addr[15:0] = 16'h0C00;
        mem_rdata_vld = 1'b1; mem_rdata = 32'h1000;
        #1 chk("s2_gnt_with_pop", gnt, 2'b01);
        tick();
        chk("s2_outst_keep", outst_cnt, 3'd4);
        chk("s2_rsp0", rsp_vld, 2'b01);
        chk("s2_rdata0", rsp_rdata, 32'h1000);
        chk("s2_addr_c00", mem_addr, 16'h0C00);
        req = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            mem_rdata = 32'h1000 + k;
            tick();
            chk("s2_rsp_owner", rsp_vld, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("s2_rsp_data", rsp_rdata, 32'h1000 + k);
        end
        mem_rdata_vld = 1'b0;
        chk("s2_outst_empty", outst_cnt, 3'd0);

        // backpressure
        do_reset();
        req = 2'b01; req_write = 2'b01; req_addr[15:0] = 16'h0100;
        req_wdata[31:0] = 32'h55; mem_ready = 1'b0;
        #1 chk("s3_gnt", gnt, 2'b01);
        tick();
        chk("s3_mem_req", mem_req, 1'b1);
        req = 2'b10; req_write = 2'b00; req_addr[31:16] = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            #1 chk("s3_gnt_stall", gnt, 2'b00);
            tick();
            chk("s3_addr_hold", mem_addr, 16'h0100);
            chk("s3_req_hold", mem_req, 1'b1);
            chk("s3_write_hold", mem_write, 1'b1);
        end
        mem_ready = 1'b1;
        #1 chk("s3_gnt_resume", gnt, 2'b10);
        tick();
        chk("s3_addr_next", mem_addr, 16'h0200);
        chk("s3_write_next", mem_write, 1'b0);
        chk("s3_outst", outst_cnt, 3'd1);
        req = 2'b00;
        tick();
        chk("s3_no_dup", mem_req, 1'b0);
        mem_rdata_vld = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("s3_rsp_vld", rsp_vld, 2'b10);
        mem_rdata_vld = 1'b0;

        // orphan beat
        do_reset();
        mem_rdata_vld = 1'b1; mem_rdata = 32'h99;
        tick();
        chk("s4_orphan", err_orphan, 1'b1);
        chk("s4_rsp_vld", rsp_vld, 2'b00);
        chk("s4_outst", outst_cnt, 3'd0);
        mem_rdata_vld = 1'b0;
        tick();
        chk("s4_orphan_sticky", err_orphan, 1'b1);

        // reset mid-burst
        do_reset();
        chk("s5_orphan_clr", err_orphan, 1'b0);
        req = 2'b11; req_write = 2'b00; mem_ready = 1'b1;
        tick(); tick(); tick();
        chk("s5_outst3", outst_cnt, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_mem_req", mem_req, 1'b0);
        chk("s5_rst_outst", outst_cnt, 3'd0);
        chk("s5_rst_gnt", gnt, 2'b00);
        tick();
        rst_n = 1'b1;
        #1 chk("s5_gnt_first", gnt, 2'b01);
        req = 2'b00;
        mem_rdata_vld = 1'b1;
        tick();
        chk("s5_late_orphan", err_orphan, 1'b1);
        mem_rdata_vld = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
